// File: rtl/jt08_adpcmb_pkg.sv
// Shared types and defaults for the ADPCM-B sample memory arbiter.
package jt08_adpcmb_pkg;

    localparam int unsigned AW_DEFAULT     = 21;
    localparam int unsigned STARVE_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRV  = 2'd1,
        ST_LD   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/jt08_strobe_edge.sv
// Falling-edge detector for an active-low strobe. The previous value resets to 1,
// so a strobe that is already low when reset is released counts as an edge.
module jt08_strobe_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n,
    output logic fall_c
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= strobe_n;
    end

    assign fall_c = prev & ~strobe_n;

endmodule

// File: rtl/jt08_adpcmb_mem_arb.sv
// Shares one ADPCM-B sample memory between the drvB strobe port and a host loader,
// issuing single req/ack transactions downstream with bounded loader starvation.
module jt08_adpcmb_mem_arb
    import jt08_adpcmb_pkg::*;
#(
    parameter int unsigned AW     = AW_DEFAULT,
    parameter int unsigned STARVE = STARVE_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] drv_addr,
    input  logic          drv_roe_n,
    input  logic          drv_wr_n,
    input  logic [7:0]    drv_dout,
    output logic [7:0]    drv_din,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_wdata,
    output logic [7:0]    ld_rdata,
    output logic          ld_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ack,
    output logic          busy
);

    localparam int unsigned CW = $clog2(STARVE + 1);

    arb_state_e    state;
    logic [CW-1:0] starve_cnt;
    logic          drv_pend;
    logic          drv_we;
    logic [AW-1:0] drv_lat_addr;
    logic [7:0]    drv_lat_data;

    logic rd_fall_c, wr_fall_c, edge_c;
    logic drv_done_c, go_drv_c, go_ld_c;

    jt08_strobe_edge u_rd_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .strobe_n (drv_roe_n),
        .fall_c   (rd_fall_c)
    );

    jt08_strobe_edge u_wr_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .strobe_n (drv_wr_n),
        .fall_c   (wr_fall_c)
    );

    assign edge_c     = rd_fall_c | wr_fall_c;
    assign drv_done_c = (state == ST_DRV) && mem_ack;
    assign go_drv_c   = drv_pend && (!ld_req || (starve_cnt < CW'(STARVE)));
    assign go_ld_c    = ld_req && (!drv_pend || (starve_cnt == CW'(STARVE)));

    // Driver request capture; a completing access frees the slot for an edge in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_pend     <= 1'b0;
            drv_we       <= 1'b0;
            drv_lat_addr <= '0;
            drv_lat_data <= '0;
        end else begin
            if (drv_done_c) drv_pend <= 1'b0;
            if (edge_c && (!drv_pend || drv_done_c)) begin
                drv_pend     <= 1'b1;
                drv_we       <= wr_fall_c;
                drv_lat_addr <= drv_addr;
                drv_lat_data <= drv_dout;
            end
        end
    end

    // Arbitration FSM with registered downstream and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            drv_din    <= '0;
            ld_rdata   <= '0;
            ld_ack     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            ld_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go_drv_c) begin
                        state     <= ST_DRV;
                        mem_req   <= 1'b1;
                        mem_we    <= drv_we;
                        mem_addr  <= drv_lat_addr;
                        mem_wdata <= drv_lat_data;
                        busy      <= 1'b1;
                    end else if (go_ld_c) begin
                        state     <= ST_LD;
                        mem_req   <= 1'b1;
                        mem_we    <= ld_we;
                        mem_addr  <= ld_addr;
                        mem_wdata <= ld_wdata;
                        busy      <= 1'b1;
                    end
                end
                ST_DRV: begin
                    if (mem_ack) begin
                        if (!mem_we) drv_din <= mem_rdata;
                        if (!ld_req)
                            starve_cnt <= '0;
                        else if (starve_cnt != CW'(STARVE))
                            starve_cnt <= starve_cnt + CW'(1);
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                ST_LD: begin
                    if (mem_ack) begin
                        if (!mem_we) ld_rdata <= mem_rdata;
                        ld_ack     <= 1'b1;
                        starve_cnt <= '0;
                        state      <= ST_IDLE;
                        mem_req    <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt08_adpcmb_mem_arb.sv
// Directed bench for the ADPCM-B memory arbiter; inputs driven and outputs checked on negedge.
`timescale 1ns/1ps
module tb_jt08_adpcmb_mem_arb;

    localparam int unsigned AW = 21;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] drv_addr;
    logic          drv_roe_n;
    logic          drv_wr_n;
    logic [7:0]    drv_dout;
    logic [7:0]    drv_din;
    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_wdata;
    logic [7:0]    ld_rdata;
    logic          ld_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          mem_ack;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jt08_adpcmb_mem_arb #(.AW(AW), .STARVE(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .drv_addr  (drv_addr),
        .drv_roe_n (drv_roe_n),
        .drv_wr_n  (drv_wr_n),
        .drv_dout  (drv_dout),
        .drv_din   (drv_din),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_rdata  (ld_rdata),
        .ld_ack    (ld_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; drv_addr = '0; drv_roe_n = 1'b1; drv_wr_n = 1'b1; drv_dout = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        tick(2);
        check("rst_drv_din", 32'(drv_din), 32'h0);
        check("rst_ld_rdata", 32'(ld_rdata), 32'h0);
        check("rst_ld_ack", 32'(ld_ack), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_starve", 32'(dut.starve_cnt), 32'h0);
        rst_n = 1'b1;
        tick(1);

        // Driver read at 0x00123, ack 2 cycles after mem_req
        drv_addr = 21'h00123; drv_roe_n = 1'b0;
        tick(1);
        check("t1_req_lat1", 32'(mem_req), 32'h0);
        check("t1_busy_lat1", 32'(busy), 32'h0);
        tick(1);
        check("t1_req", 32'(mem_req), 32'h1);
        check("t1_we", 32'(mem_we), 32'h0);
        check("t1_addr", 32'(mem_addr), 32'h00123);
        check("t1_busy", 32'(busy), 32'h1);
        drv_roe_n = 1'b1;
        tick(1);
        check("t1_req_hold", 32'(mem_req), 32'h1);
        tick(1);
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        tick(1);
        mem_ack = 1'b0;
        check("t1_din", 32'(drv_din), 32'h5A);
        check("t1_req_drop", 32'(mem_req), 32'h0);
        check("t1_busy_drop", 32'(busy), 32'h0);
        tick(3);
        check("t1_din_held", 32'(drv_din), 32'h5A);

        // Loader write at 0x1FFFF
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 21'h1FFFF; ld_wdata = 8'hC3;
        tick(1);
        check("t2_req", 32'(mem_req), 32'h1);
        check("t2_we", 32'(mem_we), 32'h1);
        check("t2_addr", 32'(mem_addr), 32'h1FFFF);
        check("t2_wdata", 32'(mem_wdata), 32'hC3);
        check("t2_ack_early", 32'(ld_ack), 32'h0);
        tick(1);
        mem_ack = 1'b1; mem_rdata = 8'h77;
        tick(1);
        mem_ack = 1'b0;
        check("t2_ack", 32'(ld_ack), 32'h1);
        check("t2_rdata_kept", 32'(ld_rdata), 32'h0);
        ld_req = 1'b0; ld_we = 1'b0;
        tick(1);
        check("t2_ack_pulse", 32'(ld_ack), 32'h0);
        check("t2_req_drop", 32'(mem_req), 32'h0);
        tick(1);
        check("t2_ack_once", 32'(ld_ack), 32'h0);
        check("t2_idle", 32'(busy), 32'h0);

        // Driver and loader contend with starve count 0: driver first
        drv_addr = 21'h00456; drv_roe_n = 1'b0;
        tick(1);
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 21'h0ABCD; drv_roe_n = 1'b1;
        check("t3_req_lat", 32'(mem_req), 32'h0);
        tick(1);
        check("t3_drv_req", 32'(mem_req), 32'h1);
        check("t3_drv_addr", 32'(mem_addr), 32'h00456);
        mem_ack = 1'b1; mem_rdata = 8'h11;
        tick(1);
        mem_ack = 1'b0;
        check("t3_drv_din", 32'(drv_din), 32'h11);
        check("t3_gap", 32'(mem_req), 32'h0);
        check("t3_starve1", 32'(dut.starve_cnt), 32'h1);
        check("t3_no_ack", 32'(ld_ack), 32'h0);
        tick(1);
        check("t3_ld_req", 32'(mem_req), 32'h1);
        check("t3_ld_addr", 32'(mem_addr), 32'h0ABCD);
        check("t3_ld_we", 32'(mem_we), 32'h0);
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        tick(1);
        mem_ack = 1'b0;
        check("t3_ld_ack", 32'(ld_ack), 32'h1);
        check("t3_ld_rdata", 32'(ld_rdata), 32'h3C);
        check("t3_starve0", 32'(dut.starve_cnt), 32'h0);
        ld_req = 1'b0;
        tick(1);

        // Loader starved by 8 back-to-back driver reads, then wins once
        drv_addr = 21'h00200; drv_roe_n = 1'b0;
        tick(1);
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 21'h15555; drv_roe_n = 1'b1;
        tick(1);
        check("t4_first_addr", 32'(mem_addr), 32'h00200);
        for (int i = 0; i < 8; i++) begin
            mem_ack = 1'b1; mem_rdata = 8'(i + 1);
            drv_roe_n = 1'b0; drv_addr = 21'h00201 + 21'(i);
            tick(1);
            mem_ack = 1'b0; drv_roe_n = 1'b1;
            check("t4_gap", 32'(mem_req), 32'h0);
            check("t4_din", 32'(drv_din), 32'(i + 1));
            check("t4_starve", 32'(dut.starve_cnt), 32'(i + 1));
            tick(1);
            check("t4_regrant", 32'(mem_req), 32'h1);
            if (i < 7) check("t4_drv_addr", 32'(mem_addr), 32'h00201 + 32'(i));
            else       check("t4_ld_wins", 32'(mem_addr), 32'h15555);
        end
        mem_ack = 1'b1; mem_rdata = 8'h99;
        tick(1);
        mem_ack = 1'b0;
        check("t4_ld_ack", 32'(ld_ack), 32'h1);
        check("t4_ld_rdata", 32'(ld_rdata), 32'h99);
        check("t4_starve_clr", 32'(dut.starve_cnt), 32'h0);
        ld_req = 1'b0;
        tick(1);
        check("t4_pend_drv", 32'(mem_addr), 32'h00208);
        check("t4_pend_req", 32'(mem_req), 32'h1);
        mem_ack = 1'b1; mem_rdata = 8'h42;
        tick(1);
        mem_ack = 1'b0;
        check("t4_last_din", 32'(drv_din), 32'h42);
        check("t4_idle", 32'(busy), 32'h0);

        // Write strobe edge while a driver read is active is dropped
        drv_addr = 21'h00300; drv_roe_n = 1'b0;
        tick(1);
        drv_roe_n = 1'b1;
        tick(1);
        check("t5_req", 32'(mem_req), 32'h1);
        drv_wr_n = 1'b0; drv_addr = 21'h00311; drv_dout = 8'hEE;
        tick(1);
        drv_wr_n = 1'b1;
        check("t5_busy", 32'(busy), 32'h1);
        check("t5_we_stable", 32'(mem_we), 32'h0);
        check("t5_addr_stable", 32'(mem_addr), 32'h00300);
        tick(1);
        mem_ack = 1'b1; mem_rdata = 8'h5C;
        tick(1);
        mem_ack = 1'b0;
        check("t5_din", 32'(drv_din), 32'h5C);
        check("t5_drop", 32'(mem_req), 32'h0);
        tick(1);
        check("t5_no_second", 32'(mem_req), 32'h0);
        check("t5_no_busy", 32'(busy), 32'h0);

        // Both strobes fall together: write
        drv_addr = 21'h0F0F0; drv_dout = 8'hAB; drv_roe_n = 1'b0; drv_wr_n = 1'b0;
        tick(1);
        drv_roe_n = 1'b1; drv_wr_n = 1'b1;
        tick(1);
        check("t6_req", 32'(mem_req), 32'h1);
        check("t6_we", 32'(mem_we), 32'h1);
        check("t6_wdata", 32'(mem_wdata), 32'hAB);
        check("t6_addr", 32'(mem_addr), 32'h0F0F0);
        mem_ack = 1'b1; mem_rdata = 8'h66;
        tick(1);
        mem_ack = 1'b0;
        check("t6_din_kept", 32'(drv_din), 32'h5C);

        // Stray ack in IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        tick(1);
        mem_ack = 1'b0;
        check("t7_din", 32'(drv_din), 32'h5C);
        check("t7_ld_ack", 32'(ld_ack), 32'h0);
        check("t7_ld_rdata", 32'(ld_rdata), 32'h99);
        check("t7_req", 32'(mem_req), 32'h0);

        // Reset during a loader access with a driver access pending
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 21'h0AAAA; ld_wdata = 8'h5F;
        tick(1);
        check("t8_req", 32'(mem_req), 32'h1);
        drv_addr = 21'h00777; drv_roe_n = 1'b0;
        tick(1);
        drv_roe_n = 1'b1;
        check("t8_still_ld", 32'(mem_addr), 32'h0AAAA);
        rst_n = 1'b0;
        #1;
        check("t8_rst_req", 32'(mem_req), 32'h0);
        check("t8_rst_busy", 32'(busy), 32'h0);
        check("t8_rst_ack", 32'(ld_ack), 32'h0);
        check("t8_rst_din", 32'(drv_din), 32'h0);
        check("t8_rst_rdata", 32'(ld_rdata), 32'h0);
        check("t8_rst_addr", 32'(mem_addr), 32'h0);
        check("t8_rst_we", 32'(mem_we), 32'h0);
        check("t8_rst_wdata", 32'(mem_wdata), 32'h0);
        ld_req = 1'b0; ld_we = 1'b0;
        tick(1);
        mem_ack = 1'b1;
        tick(1);
        mem_ack = 1'b0;
        check("t8_no_ack", 32'(ld_ack), 32'h0);
        rst_n = 1'b1;
        tick(2);
        check("t8_pend_lost", 32'(mem_req), 32'h0);
        check("t8_idle", 32'(busy), 32'h0);
        drv_addr = 21'h00ABC; drv_roe_n = 1'b0;
        tick(1);
        drv_roe_n = 1'b1;
        tick(1);
        check("t8_new_req", 32'(mem_req), 32'h1);
        check("t8_new_addr", 32'(mem_addr), 32'h00ABC);
        mem_ack = 1'b1; mem_rdata = 8'hD4;
        tick(1);
        mem_ack = 1'b0;
        check("t8_new_din", 32'(drv_din), 32'hD4);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
